traffic_gen: RTL and testbench

TRAFFIC_GEN -- requirements
Module: traffic_gen

---
 rtl/traffic_gen_pkg.sv | 36 +++
 rtl/traffic_gen_lfsr.sv | 38 +++
 rtl/traffic_gen.sv | 153 +++++++++++++++
 tb/tb_traffic_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_gen_pkg.sv
// Shared types and constants for the traffic generator: FSM states, pattern modes,
// the fixed word table and Galois LFSR tap selection.
package traffic_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_TABLE   = 2'd0;
    localparam logic [1:0] MODE_INC     = 2'd1;
    localparam logic [1:0] MODE_LFSR    = 2'd2;
    localparam logic [1:0] MODE_INC_ALT = 2'd3;

    localparam int unsigned TABLE_LEN = 6;
    localparam logic [7:0] PATTERN_TABLE [TABLE_LEN] = '{8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    localparam logic [63:0] LFSR_TAPS_8 = 64'hB8;

    // Right-shifting Galois taps; widths without a listed polynomial fall back to MSB-only feedback.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            4:       return 64'hC;
            8:       return LFSR_TAPS_8;
            16:      return 64'hB400;
            default: return 64'(1) << (width - 1);
        endcase
    endfunction

    function automatic logic [2:0] table_next(input logic [2:0] idx);
        return (idx == 3'(TABLE_LEN - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/traffic_gen_lfsr.sv
// Galois LFSR word source: load sets the register, advance steps it one position.
module traffic_gen_lfsr
    import traffic_gen_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] value_o
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (advance_i) begin
            value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/traffic_gen.sv
// Burst traffic generator (table / increment / LFSR patterns) with full-backpressure.
// Optional inter-word idle gap enabled by defining TRAFFIC_GEN_GAP_EN.
module traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              full,
    output logic [DATA_W-1:0] DATA_IN,
    output logic              WRITE,
    output logic              init,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_cnt
);

`ifdef TRAFFIC_GEN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1) + 1;

    state_e            state_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seed_q, data_q, data_d, first_word, lfsr_val;
    logic [LEN_W-1:0]  len_q, cnt_q, cnt_d;
    logic [2:0]        tidx_q, tidx_d;
    logic [GAP_W-1:0]  gap_q;
    logic              write_q, init_q, busy_q, done_q;
    logic              xfer, lfsr_load, lfsr_adv;

    always_comb begin
        xfer      = (state_q == ST_SEND) && write_q && !full;
        cnt_d     = cnt_q + LEN_W'(1);
        tidx_d    = table_next(tidx_q);
        lfsr_load = (state_q == ST_INIT);
        lfsr_adv  = xfer && (mode_q == MODE_LFSR);
        case (mode_q)
            MODE_TABLE: begin
                first_word = DATA_W'(PATTERN_TABLE[0]);
                data_d     = DATA_W'(PATTERN_TABLE[tidx_d]);
            end
            MODE_LFSR: begin
                // An all-zero seed would lock the LFSR, so it starts from 1 instead.
                first_word = (seed_q == '0) ? DATA_W'(1) : seed_q;
                data_d     = data_q;
            end
            default: begin
                first_word = seed_q;
                data_d     = data_q + DATA_W'(1);
            end
        endcase
    end

    traffic_gen_lfsr #(.DATA_W(DATA_W)) u_lfsr (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (lfsr_load),
        .load_val_i (first_word),
        .advance_i  (lfsr_adv),
        .value_o    (lfsr_val)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_TABLE;
            seed_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
            tidx_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            write_q <= 1'b0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q  <= mode;
                        seed_q  <= seed;
                        len_q   <= burst_len;
                        cnt_q   <= '0;
                        init_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    init_q <= 1'b0;
                    tidx_q <= '0;
                    data_q <= first_word;
                    gap_q  <= '0;
                    if (len_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        write_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        cnt_q  <= cnt_d;
                        data_q <= data_d;
                        tidx_q <= tidx_d;
                        if (cnt_d == len_q) begin
                            write_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (GAP_EN && GAP_CYCLES != 0) begin
                            write_q <= 1'b0;
                            gap_q   <= GAP_W'(GAP_CYCLES);
                        end
                    end else if (gap_q != '0) begin
                        // WRITE returns on the cycle after the gap counter runs out.
                        gap_q <= gap_q - GAP_W'(1);
                        if (gap_q == GAP_W'(1)) begin
                            write_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DATA_IN  = (mode_q == MODE_LFSR) ? lfsr_val : data_q;
    assign WRITE    = write_q;
    assign init     = init_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_traffic_gen.sv
// Directed self-checking bench for traffic_gen: patterns, backpressure, zero-length, reset abort.
module tb_traffic_gen;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] burst_len;
    logic       full;
    logic [7:0] DATA_IN;
    logic       WRITE;
    logic       init;
    logic       busy;
    logic       done;
    logic [7:0] word_cnt;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_a [8];
    logic [31:0] wpat;
    int          nw;

    always #5 CLK = ~CLK;

    traffic_gen dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .burst_len (burst_len),
        .full      (full),
        .DATA_IN   (DATA_IN),
        .WRITE     (WRITE),
        .init      (init),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input logic [1:0] m, input logic [7:0] s, input logic [7:0] len,
                       input int stall_at, input int stall_n);
        int         cycles;
        int         stalls;
        logic [7:0] held;
        cycles = 0;
        stalls = 0;
        got_q.delete();
        wpat = '0;
        nw   = 0;
        mode = m;
        seed = s;
        burst_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init", init, 1);
        chk("init_busy", busy, 1);
        chk("init_write", WRITE, 0);
        chk("init_cnt", word_cnt, 0);
        tick();
        while (busy && cycles < 200) begin
            wpat = {wpat[30:0], WRITE};
            nw++;
            if (WRITE && got_q.size() == stall_at && stalls < stall_n) begin
                full = 1'b1;
                held = DATA_IN;
                tick();
                stalls++;
                chk("stall_write", WRITE, 1);
                chk("stall_data", DATA_IN, held);
            end else begin
                full = 1'b0;
                if (WRITE) got_q.push_back(DATA_IN);
                tick();
            end
            cycles++;
        end
        full = 1'b0;
        chk("no_timeout", 32'(cycles < 200), 1);
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_write", WRITE, 0);
        chk("done_init", init, 0);
        chk("done_cnt", word_cnt, len);
        tick();
        chk("done_once", done, 0);
    endtask

    task automatic chk_words(input string tag, input int n);
        chk({tag, "_n"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            chk(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, exp_a[i]);
        end
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        seed = 8'h00;
        burst_len = 8'd0;
        full = 1'b0;
        tick();
        tick();
        chk("rst_data", DATA_IN, 0);
        chk("rst_write", WRITE, 0);
        chk("rst_init", init, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", word_cnt, 0);
        RESET = 1'b0;
        tick();

        run(2'd0, 8'h00, 8'd8, -1, 0);
        exp_a = '{8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hAA};
        chk_words("table", 8);
`ifndef TRAFFIC_GEN_GAP_EN
        chk("table_cycles", nw, 8);
        chk("table_wpat", wpat, 32'hFF);
`endif

        run(2'd1, 8'hFE, 8'd4, -1, 0);
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_words("inc_wrap", 4);

        run(2'd1, 8'h10, 8'd3, 1, 3);
        exp_a = '{8'h10, 8'h11, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_words("stall", 3);
`ifndef TRAFFIC_GEN_GAP_EN
        chk("stall_cycles", nw, 6);
`endif

        run(2'd2, 8'h00, 8'd3, -1, 0);
        exp_a = '{8'h01, 8'hB8, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_words("lfsr", 3);

        run(2'd2, 8'h00, 8'd0, -1, 0);
        chk("zero_len_words", got_q.size(), 0);
        chk("zero_len_cycles", nw, 0);

        run(2'd3, 8'h7F, 8'd2, -1, 0);
        exp_a = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_words("mode3", 2);

        mode = 2'd1;
        seed = 8'h20;
        burst_len = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_w0", DATA_IN, 8'h20);
        tick();
        tick();
        chk("abort_cnt2", word_cnt, 2);
        RESET = 1'b1;
        tick();
        chk("abort_data", DATA_IN, 0);
        chk("abort_write", WRITE, 0);
        chk("abort_init", init, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", word_cnt, 0);
        RESET = 1'b0;
        tick();
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);

        run(2'd1, 8'h30, 8'd2, -1, 0);
        exp_a = '{8'h30, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_words("after_abort", 2);

`ifdef TRAFFIC_GEN_GAP_EN
        run(2'd1, 8'h40, 8'd3, -1, 0);
        exp_a = '{8'h40, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_words("gap", 3);
        chk("gap_pat", wpat, 32'b1001001);
        chk("gap_cycles", nw, 7);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
